// File: rtl/debounce_multi.sv
// N-channel button debouncer: 2-FF synchroniser, stability filter, press/release
// pulses and optional hold-to-auto-repeat per channel, plus an aggregate event flag.
module debounce_multi #(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int ACTIVE_LOW      = 0,
    parameter int REPEAT_EN       = 0,
    parameter int HOLD_CYCLES     = 5000000,
    parameter int REPEAT_CYCLES   = 1000000,
    parameter int RPT_W           = 23
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] button_in,
    output logic [CHANNELS-1:0] button_out,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] repeat_pulse,
    output logic                any_event
);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rpt_state_e;

    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CHANNELS-1:0] INV_MASK = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [CHANNELS-1:0] in_norm;
    logic [CHANNELS-1:0] sync_s1;
    logic [CHANNELS-1:0] sync_s2;
    logic [CHANNELS-1:0] out_next;

    // Inverting before the synchroniser keeps a released button at 0 through reset.
    assign in_norm = button_in ^ INV_MASK;

    // NOTE: non-blocking assignments let s2 take the old s1, forming a true 2-stage chain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_s1 <= '0;
            sync_s2 <= '0;
        end else begin
            sync_s1 <= in_norm;
            sync_s2 <= sync_s1;
        end
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
        logic [CNT_W-1:0] cnt;
        logic             out_q;
        logic             press_q;
        logic             release_q;
        logic             accept;

        assign accept       = (sync_s2[ch] != out_q) && (cnt == CNT_LAST);
        assign out_next[ch] = accept ? sync_s2[ch] : out_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt       <= '0;
                out_q     <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                out_q     <= out_next[ch];
                press_q   <= accept & sync_s2[ch];
                release_q <= accept & ~sync_s2[ch];
                // Any agreement with the accepted level restarts the window.
                if (sync_s2[ch] == out_q || accept)
                    cnt <= '0;
                else
                    cnt <= cnt + 1'b1;
            end
        end

        assign button_out[ch]    = out_q;
        assign press_pulse[ch]   = press_q;
        assign release_pulse[ch] = release_q;

        if (REPEAT_EN != 0) begin : g_repeat
            localparam logic [RPT_W-1:0] HOLD_LAST = RPT_W'(HOLD_CYCLES - 1);
            localparam logic [RPT_W-1:0] RPT_LAST  = RPT_W'(REPEAT_CYCLES - 1);

            rpt_state_e       state;
            rpt_state_e       state_next;
            logic [RPT_W-1:0] rc;
            logic [RPT_W-1:0] rc_next;
            logic             fire;
            logic             rpt_q;
            logic             press_evt;

            // Acting on the accept cycle puts the first repeat HOLD_CYCLES after press_pulse.
            assign press_evt = out_next[ch] & ~out_q;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    state <= IDLE;
                    rc    <= '0;
                    rpt_q <= 1'b0;
                end else begin
                    state <= state_next;
                    rc    <= rc_next;
                    rpt_q <= fire;
                end
            end

            // NOTE: every always_comb output gets a default first so no latch is inferred.
            always_comb begin
                state_next = state;
                if (!out_next[ch])
                    state_next = IDLE;
                else begin
                    case (state)
                        IDLE:    if (press_evt) state_next = HOLD;
                        HOLD:    if (rc == HOLD_LAST) state_next = REPEAT;
                        default: state_next = state;
                    endcase
                end
            end

            always_comb begin
                fire    = 1'b0;
                rc_next = rc + 1'b1;
                case (state)
                    HOLD: if (rc == HOLD_LAST) begin
                        fire    = 1'b1;
                        rc_next = '0;
                    end
                    REPEAT: if (rc == RPT_LAST) begin
                        fire    = 1'b1;
                        rc_next = '0;
                    end
                    default: rc_next = '0;
                endcase
                // A released level (including the release cycle itself) suppresses repeats.
                if (!out_next[ch]) begin
                    fire    = 1'b0;
                    rc_next = '0;
                end
            end

            assign repeat_pulse[ch] = rpt_q;
        end else begin : g_no_repeat
            assign repeat_pulse[ch] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            any_event <= 1'b0;
        else
            any_event <= |(press_pulse | release_pulse | repeat_pulse);
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi: three builds (main, active-low, single-cycle filter)
// with expected pulse events queued at stimulus time and matched when the DUT pulses.
module tb_debounce_multi;

    typedef enum {EV_PRESS, EV_RELEASE, EV_REPEAT, EV_ANY} ev_kind_e;
    typedef struct {
        int       dut;
        ev_kind_e kind;
        int       ch;
        int       cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] in0 = 4'h0, out0, pr0, rl0, rp0;
    logic [3:0] in1 = 4'hF, out1, pr1, rl1, rp1;
    logic [1:0] in2 = 2'b00, out2, pr2, rl2, rp2;
    logic       any0, any1, any2;

    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;
    bit  mon_en  = 1'b0;
    ev_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    debounce_multi #(.CHANNELS(4), .DEBOUNCE_CYCLES(4), .CNT_W(3), .ACTIVE_LOW(0),
                     .REPEAT_EN(1), .HOLD_CYCLES(10), .REPEAT_CYCLES(5), .RPT_W(4)) u_main (
        .clk(clk), .reset(reset), .button_in(in0), .button_out(out0), .press_pulse(pr0),
        .release_pulse(rl0), .repeat_pulse(rp0), .any_event(any0));

    debounce_multi #(.CHANNELS(4), .DEBOUNCE_CYCLES(4), .CNT_W(3), .ACTIVE_LOW(1),
                     .REPEAT_EN(0)) u_low (
        .clk(clk), .reset(reset), .button_in(in1), .button_out(out1), .press_pulse(pr1),
        .release_pulse(rl1), .repeat_pulse(rp1), .any_event(any1));

    debounce_multi #(.CHANNELS(2), .DEBOUNCE_CYCLES(1), .CNT_W(1), .ACTIVE_LOW(0),
                     .REPEAT_EN(0)) u_fast (
        .clk(clk), .reset(reset), .button_in(in2), .button_out(out2), .press_pulse(pr2),
        .release_pulse(rl2), .repeat_pulse(rp2), .any_event(any2));

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_ev(input int d, input ev_kind_e k, input int ch, input int at);
        ev_t e;
        e.dut  = d;
        e.kind = k;
        e.ch   = ch;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic match(input int d, input ev_kind_e k, input int ch);
        int idx = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].dut == d && exp_q[i].kind == k && exp_q[i].ch == ch &&
                exp_q[i].cyc == cyc) begin
                idx = i;
                break;
            end
        end
        n_tests++;
        assert ((idx >= 0) === 1'b1) else begin
            n_fail++;
            $error("FAIL event dut%0d %s ch%0d cycle %0d: observed pulse, expected none",
                   d, k.name(), ch, cyc);
        end
        if (idx >= 0) exp_q.delete(idx);
    endtask

    task automatic scan(input int d, input logic [3:0] pr, input logic [3:0] rl,
                        input logic [3:0] rp, input logic an);
        for (int ch = 0; ch < 4; ch++) begin
            if (pr[ch] === 1'b1) match(d, EV_PRESS, ch);
            if (rl[ch] === 1'b1) match(d, EV_RELEASE, ch);
            if (rp[ch] === 1'b1) match(d, EV_REPEAT, ch);
        end
        if (an === 1'b1) match(d, EV_ANY, 0);
    endtask

    task automatic drain(input string tag);
        n_tests++;
        assert (exp_q.size() === 0) else begin
            n_fail++;
            foreach (exp_q[i])
                $error("FAIL %s: missing dut%0d %s ch%0d cycle %0d, observed none", tag,
                       exp_q[i].dut, exp_q[i].kind.name(), exp_q[i].ch, exp_q[i].cyc);
        end
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            scan(0, pr0, rl0, rp0, any0);
            scan(1, pr1, rl1, rp1, any1);
            scan(2, {2'b00, pr2}, {2'b00, rl2}, {2'b00, rp2}, any2);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, p, r;
        tick(3);
        check("reset_out_main", out0, 4'h0);
        check("reset_pulses_main", {pr0, rl0, rp0}, 12'h000);
        check("reset_any_main", any0, 1'b0);
        check("reset_out_low", out1, 4'h0);
        check("reset_out_fast", out2, 2'b00);
        reset  = 1'b1;
        mon_en = 1'b1;
        tick(4);

        // Clean press and release on channel 0.
        c = cyc;
        in0[0] = 1'b1;
        expect_ev(0, EV_PRESS, 0, c + 6);
        expect_ev(0, EV_ANY, 0, c + 7);
        tick(5);
        check("clean_before_accept", out0, 4'h0);
        tick(1);
        check("clean_out", out0, 4'b0001);
        check("clean_press", pr0, 4'b0001);
        tick(1);
        check("clean_press_one_cycle", pr0, 4'b0000);
        tick(1);
        in0[0] = 1'b0;
        expect_ev(0, EV_RELEASE, 0, cyc + 6);
        expect_ev(0, EV_ANY, 0, cyc + 7);
        tick(7);
        check("clean_released", out0, 4'h0);
        tick(3);
        drain("clean");

        // Bounce on channel 1: 1,0,1,0 then a steady 1.
        in0[1] = 1'b1; tick(1);
        in0[1] = 1'b0; tick(1);
        in0[1] = 1'b1; tick(1);
        in0[1] = 1'b0; tick(1);
        in0[1] = 1'b1;
        c = cyc;
        expect_ev(0, EV_PRESS, 1, c + 6);
        expect_ev(0, EV_ANY, 0, c + 7);
        tick(6);
        check("bounce_out", out0, 4'b0010);
        tick(2);
        in0[1] = 1'b0;
        expect_ev(0, EV_RELEASE, 1, cyc + 6);
        expect_ev(0, EV_ANY, 0, cyc + 7);
        tick(10);
        drain("bounce");

        // Auto-repeat on channel 2; release lands exactly on the +40 repeat slot.
        c = cyc;
        p = c + 6;
        in0[2] = 1'b1;
        expect_ev(0, EV_PRESS, 2, p);
        expect_ev(0, EV_ANY, 0, p + 1);
        for (int k = 10; k <= 35; k += 5) begin
            expect_ev(0, EV_REPEAT, 2, p + k);
            expect_ev(0, EV_ANY, 0, p + k + 1);
        end
        tick(40);
        in0[2] = 1'b0;
        expect_ev(0, EV_RELEASE, 2, p + 40);
        expect_ev(0, EV_ANY, 0, p + 41);
        tick(20);
        check("repeat_released", out0, 4'h0);
        drain("repeat");

        // All four channels pressed on the same edge.
        c = cyc;
        in0 = 4'hF;
        for (int ch = 0; ch < 4; ch++) expect_ev(0, EV_PRESS, ch, c + 6);
        expect_ev(0, EV_ANY, 0, c + 7);
        tick(6);
        check("simul_press", pr0, 4'hF);
        tick(2);
        in0 = 4'h0;
        for (int ch = 0; ch < 4; ch++) expect_ev(0, EV_RELEASE, ch, cyc + 6);
        expect_ev(0, EV_ANY, 0, cyc + 7);
        tick(10);
        drain("simultaneous");

        // Active-low build: driving 0 is a press.
        c = cyc;
        in1[1] = 1'b0;
        expect_ev(1, EV_PRESS, 1, c + 6);
        expect_ev(1, EV_ANY, 0, c + 7);
        tick(6);
        check("low_out", out1, 4'b0010);
        tick(2);
        in1[1] = 1'b1;
        expect_ev(1, EV_RELEASE, 1, cyc + 6);
        expect_ev(1, EV_ANY, 0, cyc + 7);
        tick(10);
        drain("active_low");

        // Single-cycle filter: 3-edge latency, and a one-cycle blip is accepted.
        c = cyc;
        in2[1] = 1'b1;
        expect_ev(2, EV_PRESS, 1, c + 3);
        expect_ev(2, EV_ANY, 0, c + 4);
        tick(2);
        check("fast_before_accept", out2, 2'b00);
        tick(1);
        check("fast_out", out2, 2'b10);
        tick(2);
        in2[1] = 1'b0;
        expect_ev(2, EV_RELEASE, 1, cyc + 3);
        expect_ev(2, EV_ANY, 0, cyc + 4);
        tick(8);
        c = cyc;
        in2[0] = 1'b1;
        tick(1);
        in2[0] = 1'b0;
        expect_ev(2, EV_PRESS, 0, c + 3);
        expect_ev(2, EV_ANY, 0, c + 4);
        expect_ev(2, EV_RELEASE, 0, c + 4);
        expect_ev(2, EV_ANY, 0, c + 5);
        tick(8);
        drain("fast");

        // Reset mid-hold (ch0) and mid-count (ch3); both must requalify afterwards.
        c = cyc;
        in0[0] = 1'b1;
        expect_ev(0, EV_PRESS, 0, c + 6);
        expect_ev(0, EV_ANY, 0, c + 7);
        tick(8);
        check("pre_reset_out", out0, 4'b0001);
        in0[3] = 1'b1;
        tick(3);
        reset = 1'b0;
        #1;
        check("midreset_out", out0, 4'h0);
        check("midreset_pulses", {pr0, rl0, rp0}, 12'h000);
        check("midreset_any", any0, 1'b0);
        drain("pre_reset");
        tick(3);
        reset = 1'b1;
        r = cyc;
        expect_ev(0, EV_PRESS, 0, r + 6);
        expect_ev(0, EV_PRESS, 3, r + 6);
        expect_ev(0, EV_ANY, 0, r + 7);
        tick(5);
        check("requalify_wait", out0, 4'h0);
        tick(1);
        check("requalify_out", out0, 4'b1001);
        tick(2);
        in0 = 4'h0;
        expect_ev(0, EV_RELEASE, 0, cyc + 6);
        expect_ev(0, EV_RELEASE, 3, cyc + 6);
        expect_ev(0, EV_ANY, 0, cyc + 7);
        tick(10);
        drain("reset");
        check("final_low_idle", out1, 4'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
